// File: rtl/alu_div_seq.sv
// Unsigned restoring divider for the ALU divide opcode: one quotient bit per clock.
// Latency: done pulses WIDTH+1 cycles after an accepted start (the cycle right after the start for divide-by-zero).
// Backpressure: start is only accepted in IDLE; it is ignored during CALC/DONE and never queued.
module alu_div_seq #(
  parameter int WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   num1,
  input  logic [WIDTH-1:0]   num2,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic [2*WIDTH-1:0] alu_10bitout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  // Dividend is shifted out of the top of q_q while quotient bits shift in at the bottom.
  logic [WIDTH-1:0] q_q, q_d;
  // After each restoring step the partial remainder is below the divisor, so it fits WIDTH bits;
  // only the shifted intermediate needs the extra bit.
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   r_sub;
  logic             r_ge;

  // One shift-and-subtract step on the current working registers.
  always_comb begin
    r_shift = {r_q, q_q[WIDTH-1]};
    r_sub   = r_shift - {1'b0, dvsr_q};
    r_ge    = (r_shift >= {1'b0, dvsr_q});
  end

  // Next-state and datapath update for the three-state divider FSM.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (num2 != '0) begin
            q_d     = num1;
            r_d     = '0;
            dvsr_d  = num2;
            cnt_d   = CW'(WIDTH);
            dbz_d   = 1'b0;
            state_d = CALC;
          end else begin
            // Divide by zero skips the iterations and reports a saturated quotient.
            q_d     = '1;
            r_d     = num1;
            dbz_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      CALC: begin
        if (r_ge) begin
          r_d = r_sub[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = r_shift[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and working registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy         = (state_q == CALC);
  assign done         = (state_q == DONE);
  assign div_by_zero  = dbz_q;
  assign quotient     = q_q;
  assign remainder    = r_q;
  assign alu_10bitout = {r_q, q_q};

endmodule
